// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: ISA constants, fetch states, queue entry.
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_HALT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// First-word-fall-through fetch queue holding {pc,instr} entries.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fq_entry_t                din,
    output fq_entry_t                dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_ok;
    fq_entry_t     mem [DEPTH];

    assign pop_ok = pop & (count != '0);
    assign dout = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: count gates what is visible.
    always_ff @(posedge clock) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch PC, run/halt control and redirect handling in front of the
// fetch queue feeding decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_instr,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [$clog2(FQ_DEPTH):0]  fq_count,
    output logic                       halted
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic            push;
    logic            pop;
    fq_entry_t       head;

    assign imem_addr = fetch_pc;
    assign out_valid = fq_count != '0;
    assign pop       = out_valid & out_ready;
    // A pop frees the slot this cycle, so a full queue still accepts.
    assign push      = (state == FS_RUN) & ~redirect_valid
                     & ((fq_count != FULL) | pop);
    assign halted    = state == FS_HALT;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= FS_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = FS_RUN;
        else if (push && imem_instr == INSTR_HALT)
            state_nxt = FS_HALT;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (push)
            fetch_pc <= fetch_pc + 32'd4;
    end

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_fq (
        .clock (clock),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: fetch_pc, instr: imem_instr}),
        .dout  (head),
        .count (fq_count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based fetch model.
module tb_fetch_unit;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  fq_count;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic        m_halt;

    fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .fq_count(fq_count), .halted(halted)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] n;
        n = a >> 2;
        if (n == 32'd8) return 32'h0;
        return 32'h0000_0093 + (n << 20);
    endfunction

    assign imem_instr = word(imem_addr);

    function automatic logic [31:0] e_pc();
        logic [63:0] h;
        if (mq.size() == 0) return 32'h0;
        h = mq[0];
        return h[63:32];
    endfunction

    function automatic logic [31:0] e_instr();
        logic [63:0] h;
        if (mq.size() == 0) return 32'h0;
        h = mq[0];
        return h[31:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc = 32'h0;
        m_halt = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [31:0] rp,
                              input logic rdy);
        logic [31:0] w;
        if (r) begin
            mq.delete();
            m_pc = {rp[31:2], 2'b00};
            m_halt = 1'b0;
        end else begin
            if (mq.size() > 0 && rdy) void'(mq.pop_front());
            if (!m_halt && mq.size() < DEPTH) begin
                w = word(m_pc);
                mq.push_back({m_pc, w});
                if (w == 32'h0) m_halt = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic step(input logic r, input logic [31:0] rp,
                        input logic rdy);
        redirect_valid = r;
        redirect_pc = rp;
        out_ready = rdy;
        @(posedge clock);
        model_step(r, rp, rdy);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        model_step(1'b0, 32'h0, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        #1;
        checks += 6;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid got %0b want 0", out_valid); end
        if (fq_count !== 3'd0) begin errors++;
            $display("FAIL reset_count got %0d want 0", fq_count); end
        if (imem_addr !== 32'h0) begin errors++;
            $display("FAIL reset_addr got %h want 0", imem_addr); end
        if (halted !== 1'b0) begin errors++;
            $display("FAIL reset_halted got %0b want 0", halted); end
        if (out_pc !== 32'h0) begin errors++;
            $display("FAIL reset_pc got %h want 0", out_pc); end
        if (out_instr !== 32'h0) begin errors++;
            $display("FAIL reset_instr got %h want 0", out_instr); end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_fill();
        logic [31:0] exp_addr [6];
        exp_addr = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h10, 32'h10};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b0);
            checks++;
            if (imem_addr !== exp_addr[i]) begin errors++;
                $display("FAIL fill_addr[%0d] got %h want %h",
                         i, imem_addr, exp_addr[i]); end
        end
        checks += 3;
        if (fq_count !== 3'd4) begin errors++;
            $display("FAIL fill_count got %0d want 4", fq_count); end
        if (out_pc !== 32'h0) begin errors++;
            $display("FAIL fill_pc got %h want 0", out_pc); end
        if (out_instr !== 32'h0000_0093) begin errors++;
            $display("FAIL fill_instr got %h want 93", out_instr); end
    endtask

    task automatic test_stream();
        logic [31:0] prev;
        prev = out_pc;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1);
            checks += 3;
            if (out_pc !== prev + 32'd4) begin errors++;
                $display("FAIL stream_pc got %h want %h", out_pc, prev + 4); end
            if (fq_count !== 3'd4) begin errors++;
                $display("FAIL stream_count got %0d want 4", fq_count); end
            if (out_instr !== e_instr()) begin errors++;
                $display("FAIL stream_instr got %h want %h",
                         out_instr, e_instr()); end
            prev = prev + 32'd4;
        end
    endtask

    task automatic test_redirect_full();
        step(1'b1, 32'h0000_0043, 1'b0);
        checks += 2;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL redir_valid got %0b want 0", out_valid); end
        if (imem_addr !== 32'h40) begin errors++;
            $display("FAIL redir_addr got %h want 40", imem_addr); end
        step(1'b0, 32'h0, 1'b0);
        checks += 3;
        if (out_pc !== 32'h40) begin errors++;
            $display("FAIL redir_pc got %h want 40", out_pc); end
        if (fq_count !== 3'd1) begin errors++;
            $display("FAIL redir_count got %0d want 1", fq_count); end
        if (out_instr !== word(32'h40)) begin errors++;
            $display("FAIL redir_instr got %h want %h",
                     out_instr, word(32'h40)); end
    endtask

    task automatic test_halt();
        bit seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (out_valid && out_pc == 32'h20) begin
                seen = 1;
                checks++;
                if (out_instr !== 32'h0) begin errors++;
                    $display("FAIL halt_word got %h want 0", out_instr); end
            end
            checks++;
            if (halted !== m_halt) begin errors++;
                $display("FAIL halt_flag[%0d] got %0b want %0b",
                         i, halted, m_halt); end
        end
        checks += 4;
        if (!seen) begin errors++;
            $display("FAIL halt_entry got none want pc 20"); end
        if (halted !== 1'b1) begin errors++;
            $display("FAIL halt_final got %0b want 1", halted); end
        if (imem_addr !== 32'h24) begin errors++;
            $display("FAIL halt_addr got %h want 24", imem_addr); end
        if (fq_count !== 3'd0) begin errors++;
            $display("FAIL halt_drain got %0d want 0", fq_count); end
        step(1'b1, 32'h0, 1'b1);
        checks += 2;
        if (halted !== 1'b0) begin errors++;
            $display("FAIL halt_clear got %0b want 0", halted); end
        if (imem_addr !== 32'h0) begin errors++;
            $display("FAIL halt_restart got %h want 0", imem_addr); end
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (fq_count !== 3'd1 || out_pc !== 32'h0) begin errors++;
            $display("FAIL halt_resume got cnt %0d pc %h want 1 0",
                     fq_count, out_pc); end
    endtask

    task automatic test_wrap();
        step(1'b1, 32'hFFFF_FFFE, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        checks += 2;
        if (out_pc !== 32'hFFFF_FFFC) begin errors++;
            $display("FAIL wrap_head got %h want fffffffc", out_pc); end
        if (fq_count !== 3'd2) begin errors++;
            $display("FAIL wrap_count got %0d want 2", fq_count); end
        step(1'b0, 32'h0, 1'b1);
        checks += 2;
        if (out_pc !== 32'h0) begin errors++;
            $display("FAIL wrap_next got %h want 0", out_pc); end
        if (out_instr !== 32'h0000_0093) begin errors++;
            $display("FAIL wrap_instr got %h want 93", out_instr); end
    endtask

    task automatic test_random();
        logic        r;
        logic [31:0] rp;
        logic        rdy;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 15) == 0);
            rp = $urandom_range(0, 63);
            rdy = $urandom_range(0, 2) != 0;
            step(r, rp, rdy);
            checks += 5;
            if (out_valid !== (mq.size() != 0)) begin errors++;
                $display("FAIL rnd_valid[%0d] got %0b want %0b",
                         i, out_valid, mq.size() != 0); end
            if (fq_count !== 3'(mq.size())) begin errors++;
                $display("FAIL rnd_count[%0d] got %0d want %0d",
                         i, fq_count, mq.size()); end
            if (out_pc !== e_pc() || out_instr !== e_instr()) begin errors++;
                $display("FAIL rnd_head[%0d] got %h/%h want %h/%h",
                         i, out_pc, out_instr, e_pc(), e_instr()); end
            if (imem_addr !== m_pc) begin errors++;
                $display("FAIL rnd_addr[%0d] got %h want %h",
                         i, imem_addr, m_pc); end
            if (halted !== m_halt) begin errors++;
                $display("FAIL rnd_halt[%0d] got %0b want %0b",
                         i, halted, m_halt); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (fq_count !== 3'd3) begin errors++;
            $display("FAIL areset_pre got %0d want 3", fq_count); end
        #2;
        reset = 1'b1;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++;
            $display("FAIL areset_valid got %0b want 0", out_valid); end
        if (fq_count !== 3'd0) begin errors++;
            $display("FAIL areset_count got %0d want 0", fq_count); end
        if (imem_addr !== 32'h0) begin errors++;
            $display("FAIL areset_addr got %h want 0", imem_addr); end
        if (halted !== 1'b0) begin errors++;
            $display("FAIL areset_halt got %0b want 0", halted); end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        checks += 2;
        if (out_pc !== 32'h0 || fq_count !== 3'd2) begin errors++;
            $display("FAIL areset_restart got pc %h cnt %0d want 0 2",
                     out_pc, fq_count); end
        if (imem_addr !== 32'h8) begin errors++;
            $display("FAIL areset_next got %h want 8", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect_full();
        test_halt();
        test_wrap();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
